// File: rtl/weighted_rr_arbiter.sv
// ---------------------------------------------------------------------------
// weighted_rr_arbiter
//
// Weighted round-robin arbiter. Once a requester wins, it keeps the grant for
// up to WEIGHTS[i] consecutive cycles, or until it drops its request. The
// search for the next owner then starts just past the previous owner. A zero
// weight behaves as a weight of one.
//
// Parameters
//   N_REQ   : number of requesters (2..16)
//   WEIGHTS : per-requester grant-cycle budget (8 bits each, 0 acts as 1)
//   IDX_W   : width of gnt_idx
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   req       : request level, bit i belongs to requester i
//   gnt       : grant, one-hot or zero, decoded from registered state only
//   gnt_valid : high whenever gnt is nonzero
//   gnt_idx   : binary index of the current owner, 0 when idle
//   gnt_last  : high in the final cycle of the current grant budget
// ---------------------------------------------------------------------------
module weighted_rr_arbiter #(
  parameter int unsigned N_REQ            = 4,
  parameter bit [7:0]    WEIGHTS [N_REQ]  = '{8'd3, 8'd1, 8'd2, 8'd1},
  parameter int unsigned IDX_W            = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [7:0]       credit_q, credit_d;

  // Effective budgets: a zero weight is promoted to one so every grant
  // lasts at least one cycle and credit never has to represent zero.
  logic [7:0] budget [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_budget
    assign budget[gi] = (WEIGHTS[gi] == 8'd0) ? 8'd1 : WEIGHTS[gi];
  end

  // (base + off) mod N_REQ, valid for base < N_REQ and off < N_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned    off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    return IDX_W'(sum);
  endfunction

  // Pointer that a rotate event installs: one past the current owner.
  logic [IDX_W-1:0] next_ptr;
  assign next_ptr = wrap_add(owner_q, 1);

  // One search engine serves both cases: from IDLE it starts at ptr, on a
  // rotate it starts at the freshly advanced pointer. Because the wrap also
  // covers the current owner, a sole requester re-wins without a bubble.
  logic [IDX_W-1:0] search_start;
  logic             found;
  logic [IDX_W-1:0] found_idx;

  assign search_start = (state_q == GRANT) ? next_ptr : ptr_q;

  // Walk the offsets from farthest to nearest so the nearest set request
  // wins.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(search_start, k)]) begin
        found     = 1'b1;
        found_idx = wrap_add(search_start, k);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = GRANT;
          owner_d  = found_idx;
          credit_d = budget[found_idx];
        end
      end
      GRANT: begin
        if (req[owner_q] && (credit_q > 8'd1)) begin
          // The owner keeps the grant. Other requests cannot preempt it here.
          credit_d = credit_q - 8'd1;
        end else begin
          // Rotate event: the budget is spent or the owner released.
          ptr_d = next_ptr;
          if (found) begin
            owner_d  = found_idx;
            credit_d = budget[found_idx];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: outputs depend only on registered state.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_last  = 1'b0;
    if (state_q == GRANT) begin
      gnt[owner_q] = 1'b1;
      gnt_valid    = 1'b1;
      gnt_idx      = owner_q;
      gnt_last     = (credit_q == 8'd1);
    end
  end

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
- REQ-001: The block SHALL have parameter N_REQ, default 4: int unsigned, number of requesters, legal range 2..16.
- REQ-002: The block SHALL have parameter WEIGHTS[N_REQ], default '{3,1,2,1}: bit [7:0] unpacked array giving the per-requester grant-cycle budget, with a 0 entry treated as 1.
- REQ-003: The block SHALL have parameter IDX_W, default $clog2(N_REQ): int unsigned, width of gnt_idx.
- REQ-004: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005: The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006: The block SHALL have port req, input, N_REQ bits: per-requester request level, with bit i belonging to requester i.
- REQ-007: The block SHALL have port gnt, output, N_REQ bits: registered grant, one-hot or zero.
- REQ-008: The block SHALL have port gnt_valid, output, 1 bit: high when gnt is nonzero.
- REQ-009: The block SHALL have port gnt_idx, output, IDX_W bits: binary index of the granted requester, 0 when gnt_valid is low.
- REQ-010: The block SHALL have port gnt_last, output, 1 bit: high in the final cycle of the current grant budget.

Function
- REQ-011: The block SHALL implement two states, IDLE and GRANT, plus registers owner (IDX_W bits), ptr (IDX_W bits) and credit (8 bits).
- REQ-012: In IDLE the block SHALL drive gnt=0, gnt_valid=0, gnt_idx=0 and gnt_last=0.
- REQ-013: In IDLE with req nonzero at a clock edge, the block SHALL:
  - select the first set req bit searching ptr, ptr+1, ... with wrap modulo N_REQ;
  - set owner to that index;
  - load credit = max(WEIGHTS[owner],1);
  - enter GRANT.
- REQ-014: Latency from req assertion to gnt assertion SHALL be exactly one clock cycle.
- REQ-015: In GRANT the block SHALL drive:
  - gnt = one-hot(owner);
  - gnt_valid = 1;
  - gnt_idx = owner;
  - gnt_last = (credit==1).
- REQ-016: At a GRANT clock edge with req[owner]=1 and credit>1, the block SHALL decrement credit and hold owner.
- REQ-017: At a GRANT clock edge with req[owner]=0 or credit==1 (rotate event), the block SHALL set ptr = (owner+1) mod N_REQ.
- REQ-018: On a rotate event, the block SHALL search for the next requester starting at the new ptr with wrap modulo N_REQ.
  - If a requester is found, it SHALL be granted in the next cycle with fresh credit, with no idle bubble.
  - If none is found, the block SHALL return to IDLE.
- REQ-019: When the sole requester exhausts its credit, the wrapped search SHALL re-select it with a fresh budget, and gnt SHALL stay continuously high.
- REQ-020: Requests from other requesters SHALL never preempt owner before a rotate event.
- REQ-021: A requester that drops req in the same cycle it is granted SHALL still be granted for that cycle; the rotate SHALL occur at the following edge.
- REQ-022: Credit arithmetic SHALL be unsigned 8-bit; credit SHALL never decrement below 1 and never wrap.
- REQ-023: At most one gnt bit SHALL ever be set, and gnt_valid SHALL equal the OR-reduction of gnt in every cycle.

Reset
- REQ-024: When rst=1 at a clock edge, the block SHALL enter IDLE and clear owner, ptr and credit to 0, overriding all other events including a mid-grant state.
- REQ-025: Outputs SHALL be 0 in the cycle following a reset edge: gnt, gnt_valid, gnt_idx and gnt_last.
- REQ-026: The first arbitration after reset SHALL search from requester 0.

Verification (N_REQ=4, WEIGHTS='{3,1,2,1} unless stated)
- REQ-027: Reset, then req=4'b1111 held: gnt SHALL follow 0001 x3, 0010 x1, 0100 x2, 1000 x1 and then repeat, with gnt_last high on the 3rd, 4th, 6th and 7th cycles.
- REQ-028: Reset, then req=4'b0001 held: gnt SHALL stay 0001 continuously from cycle 1, with gnt_last high on cycles 3, 6, 9 and so on.
- REQ-029: req=4'b0011 held, with req[0] dropped after its first grant cycle: gnt SHALL be 0001 then 0001 (the drop cycle), then 0010, and ptr SHALL become 1.
- REQ-030: req pulsed 4'b1000 for one cycle from IDLE: gnt SHALL be 1000 for one cycle with gnt_idx=3, then IDLE; ptr SHALL wrap to 0.
- REQ-031: rst asserted while owner=2 with credit=2: the next cycle SHALL show gnt=0 and gnt_valid=0; with req=4'b0110 held, the subsequent grant SHALL go to requester 1.
- REQ-032: WEIGHTS='{0,0,0,0} with req=4'b0011 held: gnt SHALL alternate 0001 and 0010 every cycle, with gnt_last high in every cycle.
